demux_capture8: RTL and testbench
=================================

Name: demux_capture8

Overview:
Registered 1-to-N demultiplexing capture block, the write-side counterpart of the 8:1 bit-select mux. Each accepted input beat routes a single bit into one position of an N-bit word. The position comes either from an explicit select or from an internal auto-incrementing pointer. When every position has been written, the block presents the assembled word on a valid/ready output handshake. It sits between a serial/bit-addressed producer and word-wide consumers.

Parameters:
N_OUT, 8, number of output bit positions; must equal 2**SEL_W
SEL_W, 3, select/pointer width

Ports:
clk  input  1  clock, rising-edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  input beat offered
in_ready  output  1  block can accept a beat
in_bit  input  1  data bit of the beat
sel  input  SEL_W  target position (manual mode)
auto_inc  input  1  1: use internal pointer; 0: use sel (sampled per beat)
clear  input  1  synchronous flush of a partial collection
out  output  N_OUT  assembled word
out_valid  output  1  out holds a complete word
out_ready  input  1  consumer accepts out
wr_mask  output  N_OUT  positions written in current collection
busy  output  1  state != IDLE

Behaviour:
- Reset (rst_n low, async): out=0, out_valid=0, wr_mask=0, buffer=0, ptr=0, state=IDLE. busy=0 and in_ready=1 while reset is held and after release.
- States: IDLE (wr_mask==0, no word held), COLLECT (wr_mask!=0), HOLD (out_valid=1).
- in_ready = (state != HOLD), combinational from state only. It never depends on in_valid.
- Beat accepted when in_valid & in_ready. pos = auto_inc ? ptr : sel. buffer[pos] <= in_bit; wr_mask[pos] <= 1.
- Auto mode: ptr increments by 1 per accepted auto beat and wraps N_OUT-1 -> 0. Manual beats do not move ptr. Modes may mix within a collection.
- Duplicate position write: bit overwritten (last write wins), wr_mask unchanged, no completion.
- Completion: the accepted beat that makes wr_mask all-ones. On the next edge:
  - out <= buffer with the completing bit merged in
  - out_valid <= 1, state -> HOLD
  - buffer, wr_mask and ptr cleared to 0
  - Latency is 1 cycle from the completing beat to out_valid.
- HOLD: out and out_valid stay stable until out_valid & out_ready. On that edge out_valid <= 0 and state -> IDLE. out keeps its last value, not zeroed. in_ready returns to 1 in the following cycle; there is no same-cycle accept.
- clear:
  - In IDLE/COLLECT: on the edge, buffer, wr_mask and ptr go to 0 and state goes to IDLE. clear has priority over a simultaneous beat, which is dropped: in_ready is still 1, so the producer must not count that beat as delivered.
  - In HOLD: clear does not affect out/out_valid; the held word is still delivered.
- Simultaneous out handshake and clear in HOLD: handshake completes, state -> IDLE.
- sel and in_bit are ignored when no beat is accepted.

Test Plan:
- Reset: assert rst_n=0 after 4 auto beats -> immediately out=0x00, out_valid=0, wr_mask=0x00, busy=0, in_ready=1; the next auto beat writes position 0.
- Auto fill: auto_inc=1, in_bit sequence 1,0,1,1,0,0,1,0 on 8 consecutive cycles -> wr_mask steps 0x01..0xFF. The cycle after the 8th beat: out=0x4D, out_valid=1, in_ready=0, wr_mask=0x00.
- Manual reverse order: auto_inc=0, sel=7..0 with in_bit=1 for odd sel -> out=0xAA, out_valid=1 one cycle after sel=0 beat.
- Duplicate write: sel=3 bit=1, then sel=3 bit=0 (wr_mask stays 0x08), then the other 7 positions with bit=1 -> out=0xF7.
- Back-pressure: hold out_ready=0 for 5 cycles after out_valid, with in_valid=1 throughout:
  - out stays stable, in_ready=0, no beats accepted.
  - Raise out_ready: out_valid=0 on the next edge, in_ready=1 on the cycle after.
- Clear: 4 auto beats, then clear=1 together with in_valid=1 -> next cycle wr_mask=0, busy=0, the beat is dropped, and the next auto beat writes position 0. clear during HOLD -> out/out_valid unchanged.

Source files
------------

// File: rtl/demux_capture8.sv
// demux_capture8: routes single-bit beats into an N-bit word and hands the completed word off over valid/ready
module demux_capture8 #(
  parameter int N_OUT = 8,
  parameter int SEL_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic             i_in_bit,
  input  logic [SEL_W-1:0] i_sel,
  input  logic             i_auto_inc,
  input  logic             i_clear,
  output logic [N_OUT-1:0] o_out,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [N_OUT-1:0] o_wr_mask,
  output logic             o_busy
);
  typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_t;
  state_t             r_state;
  logic [N_OUT-1:0]   r_buf;
  logic [N_OUT-1:0]   r_mask;
  logic [N_OUT-1:0]   r_out;
  logic               r_out_valid;
  logic [SEL_W-1:0]   r_ptr;
  logic               w_acc;
  logic [SEL_W-1:0]   w_pos;
  logic [N_OUT-1:0]   w_hot;
  logic [N_OUT-1:0]   w_buf_n;
  logic [N_OUT-1:0]   w_mask_n;
  // target position and the buffer/mask as they would look after this beat
  always_comb begin
    w_acc    = i_in_valid & o_in_ready;
    w_pos    = i_auto_inc ? r_ptr : i_sel;
    w_hot    = N_OUT'(1) << w_pos;
    w_buf_n  = (r_buf & ~w_hot) | ({N_OUT{i_in_bit}} & w_hot);
    w_mask_n = r_mask | w_hot;
  end
  // collection / hold state machine; a completing beat moves the word straight to the output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_buf       <= '0;
      r_mask      <= '0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
      r_ptr       <= '0;
    end else if (r_state == HOLD) begin
      if (i_out_ready) begin
        r_out_valid <= 1'b0;
        r_state     <= IDLE;
      end
    end else if (i_clear) begin
      r_buf   <= '0;
      r_mask  <= '0;
      r_ptr   <= '0;
      r_state <= IDLE;
    end else if (w_acc) begin
      if (&w_mask_n) begin
        r_out       <= w_buf_n;
        r_out_valid <= 1'b1;
        r_state     <= HOLD;
        r_buf       <= '0;
        r_mask      <= '0;
        r_ptr       <= '0;
      end else begin
        r_buf   <= w_buf_n;
        r_mask  <= w_mask_n;
        r_ptr   <= i_auto_inc ? r_ptr + SEL_W'(1) : r_ptr;
        r_state <= COLLECT;
      end
    end
  end
  assign o_in_ready  = r_state != HOLD;
  assign o_busy      = r_state != IDLE;
  assign o_out       = r_out;
  assign o_out_valid = r_out_valid;
  assign o_wr_mask   = r_mask;
endmodule

// File: tb/tb_demux_capture8.sv
// tb_demux_capture8: directed checks of demux_capture8 against hand-computed words
module tb_demux_capture8;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0, in_bit = 1'b0, auto_inc = 1'b0, clear = 1'b0, out_ready = 1'b0;
  logic [2:0] sel = '0;
  logic       in_ready, out_valid, busy;
  logic [7:0] out, wr_mask;
  int         n_cmp = 0, n_bad = 0;

  demux_capture8 dut (
    .clk(clk), .rst_n(rst_n), .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_in_bit(in_bit), .i_sel(sel), .i_auto_inc(auto_inc), .i_clear(clear),
    .o_out(out), .o_out_valid(out_valid), .i_out_ready(out_ready),
    .o_wr_mask(wr_mask), .o_busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  task automatic beat(input logic a, input logic [2:0] s, input logic b);
    in_valid = 1'b1; auto_inc = a; sel = s; in_bit = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  logic [7:0] pat;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out", out, 8'h00);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ready", in_ready, 1'b1);
    rst_n = 1'b1;

    // async reset in the middle of a collection
    for (int i = 0; i < 4; i++) beat(1'b1, 3'd0, 1'b1);
    chk("pre_rst_mask", wr_mask, 8'h0F);
    chk("collect_busy", busy, 1'b1);
    chk("collect_ready", in_ready, 1'b1);
    rst_n = 1'b0; #1;
    chk("arst_mask", wr_mask, 8'h00);
    chk("arst_busy", busy, 1'b0);
    chk("arst_valid", out_valid, 1'b0);
    chk("arst_ready", in_ready, 1'b1);
    #1 rst_n = 1'b1;
    beat(1'b1, 3'd5, 1'b1);
    chk("arst_ptr0", wr_mask, 8'h01);
    clear = 1'b1; tick; clear = 1'b0;
    chk("flush_mask", wr_mask, 8'h00);

    // auto fill 1,0,1,1,0,0,1,0 -> 0x4D
    pat = 8'b0100_1101;
    for (int i = 0; i < 8; i++) begin
      beat(1'b1, 3'd7, pat[i]);
      if (i < 7) chk($sformatf("auto_mask%0d", i), wr_mask, (32'd1 << (i + 1)) - 1);
    end
    chk("auto_out", out, 8'h4D);
    chk("auto_valid", out_valid, 1'b1);
    chk("auto_ready", in_ready, 1'b0);
    chk("auto_mask_clr", wr_mask, 8'h00);
    out_ready = 1'b1; tick; out_ready = 1'b0;
    chk("hs_valid", out_valid, 1'b0);
    chk("hs_out_kept", out, 8'h4D);
    chk("hs_ready", in_ready, 1'b1);
    chk("hs_busy", busy, 1'b0);

    // manual reverse order, odd positions set -> 0xAA
    for (int s = 7; s >= 0; s--) begin
      beat(1'b0, 3'(s), s[0]);
      if (s > 0) chk($sformatf("man_valid%0d", s), out_valid, 1'b0);
    end
    chk("man_out", out, 8'hAA);
    chk("man_valid", out_valid, 1'b1);

    // back-pressure with a producer that keeps offering beats
    in_valid = 1'b1; auto_inc = 1'b1; in_bit = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick;
      chk($sformatf("bp_out%0d", i), out, 8'hAA);
      chk($sformatf("bp_valid%0d", i), out_valid, 1'b1);
      chk($sformatf("bp_ready%0d", i), in_ready, 1'b0);
      chk($sformatf("bp_mask%0d", i), wr_mask, 8'h00);
    end
    out_ready = 1'b1; tick; out_ready = 1'b0;
    chk("bp_rel_valid", out_valid, 1'b0);
    chk("bp_rel_ready", in_ready, 1'b1);
    chk("bp_rel_mask", wr_mask, 8'h00);
    tick; in_valid = 1'b0;
    chk("bp_first_beat", wr_mask, 8'h01);
    clear = 1'b1; tick; clear = 1'b0;

    // duplicate write: last write wins, mask unchanged
    beat(1'b0, 3'd3, 1'b1);
    chk("dup_mask1", wr_mask, 8'h08);
    beat(1'b0, 3'd3, 1'b0);
    chk("dup_mask2", wr_mask, 8'h08);
    chk("dup_valid", out_valid, 1'b0);
    for (int s = 0; s < 8; s++) if (s != 3) beat(1'b0, 3'(s), 1'b1);
    chk("dup_out", out, 8'hF7);
    chk("dup_valid2", out_valid, 1'b1);
    out_ready = 1'b1; tick; out_ready = 1'b0;

    // clear beats a simultaneous beat; pointer restarts at 0
    for (int i = 0; i < 4; i++) beat(1'b1, 3'd0, 1'b1);
    chk("clr_pre_mask", wr_mask, 8'h0F);
    clear = 1'b1; beat(1'b1, 3'd0, 1'b1); clear = 1'b0;
    chk("clr_mask", wr_mask, 8'h00);
    chk("clr_busy", busy, 1'b0);
    chk("clr_ready", in_ready, 1'b1);
    beat(1'b1, 3'd6, 1'b0);
    chk("clr_ptr0", wr_mask, 8'h01);
    for (int i = 1; i < 8; i++) beat(1'b1, 3'd0, 1'b1);
    chk("clr_out", out, 8'hFE);
    chk("clr_valid", out_valid, 1'b1);

    // clear in HOLD leaves the word alone; clear plus handshake still hands off
    clear = 1'b1; tick;
    chk("hold_clr_out", out, 8'hFE);
    chk("hold_clr_valid", out_valid, 1'b1);
    out_ready = 1'b1; tick; out_ready = 1'b0; clear = 1'b0;
    chk("hold_clr_hs_valid", out_valid, 1'b0);
    chk("hold_clr_hs_busy", busy, 1'b0);
    chk("hold_clr_hs_out", out, 8'hFE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
